// File: rtl/la_pkg.sv
// Shared constants and state type for the logic-analyser DRAM readback path.
// Four 32-bit samples per 128-bit DRAM word; word addresses advance by 8.
package la_pkg;

    localparam int SAMPLES_PER_WORD = 4;
    localparam int WORD_ADX_STRIDE  = 8;
    localparam int SAMPLE_IDX_W     = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } unpack_state_t;

endpackage

// File: rtl/rd_word_fifo.sv
// Synchronous return-word buffer with occupancy count; read data is the
// current head entry (first-word fall-through), so a pop consumes it.
module rd_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dram_unpacker.sv
// Reads a range of captured samples back from DRAM and streams them out
// one 32-bit sample per handshake, lane 0 of each word first.
//
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_FETCH | issuing word reads, limited by buffer credits
//   ST_DRAIN | all reads issued, streaming remaining samples
//   ST_DONE  | one-cycle done pulse
module dram_unpacker
    import la_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADX_W      = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      start_sample,
    input  logic [31:0]      num_samples,
    output logic             busy,
    output logic             done,
    output logic             read_req,
    output logic [ADX_W-1:0] rd_adx,
    input  logic             read_allowed,
    input  logic             has_return_data,
    input  logic [127:0]     return_data,
    output logic             get_return_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [31:0]      sample_data,
    output logic             sample_last
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int LANE_W = $clog2(SAMPLES_PER_WORD);
    localparam int WORD_W = SAMPLE_IDX_W - LANE_W;
    localparam logic [CNT_W:0]    CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE    = LANE_W'(SAMPLES_PER_WORD - 1);

    unpack_state_t     state;
    logic [WORD_W-1:0] next_word;
    logic [WORD_W:0]   words_left;
    logic [CNT_W-1:0]  inflight;
    logic [31:0]       samples_left;
    logic [LANE_W-1:0] first_lane;
    logic              first_pending;
    logic              head_valid;
    logic [127:0]      head_data;
    logic [LANE_W-1:0] lane;

    logic [127:0]      fifo_rd_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_rd;

    logic [SAMPLE_IDX_W-1:0] first_idx;
    logic [SAMPLE_IDX_W-1:0] end_idx;
    logic [WORD_W-1:0]       first_word;
    logic [WORD_W-1:0]       last_word;
    logic [WORD_W:0]         word_count;
    logic [CNT_W:0]          credits_used;
    logic                    active;
    logic                    handshake;
    logic                    final_sample;
    logic                    word_done;
    logic                    unused_bits;

    // Sample indices live in a 2^26 ring; the word span wraps with them.
    assign first_idx  = start_sample[SAMPLE_IDX_W-1:0];
    assign end_idx    = first_idx + num_samples[SAMPLE_IDX_W-1:0] - SAMPLE_IDX_W'(1);
    assign first_word = first_idx[SAMPLE_IDX_W-1:LANE_W];
    assign last_word  = end_idx[SAMPLE_IDX_W-1:LANE_W];
    assign word_count = {1'b0, last_word - first_word} + (WORD_W + 1)'(1);
    assign unused_bits = ^start_sample[31:SAMPLE_IDX_W];

    assign active       = (state == ST_FETCH) || (state == ST_DRAIN);
    assign busy         = active;
    assign done         = (state == ST_DONE);
    assign credits_used = {1'b0, inflight} + {1'b0, fifo_count};

    assign read_req        = (state == ST_FETCH) && read_allowed && (credits_used < CREDIT_LIMIT);
    assign rd_adx          = ADX_W'(next_word) * ADX_W'(WORD_ADX_STRIDE);
    // Only pop words this run asked for; stragglers after a reset stay in ddr_if.
    assign get_return_data = active && (inflight != '0) && has_return_data && !fifo_full;

    assign sample_valid = head_valid;
    assign sample_data  = head_data[{lane, 5'b00000} +: 32];
    assign sample_last  = head_valid && final_sample;

    assign handshake    = head_valid && sample_ready;
    assign final_sample = (samples_left == 32'd1);
    assign word_done    = handshake && ((lane == LAST_LANE) || final_sample);
    assign fifo_rd      = active && !fifo_empty && (!head_valid || (word_done && !final_sample));

    rd_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (128)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (get_return_data),
        .wr_data (return_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            next_word    <= '0;
            words_left   <= '0;
            samples_left <= '0;
            first_lane   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        next_word    <= first_word;
                        words_left   <= word_count;
                        samples_left <= num_samples;
                        first_lane   <= first_idx[LANE_W-1:0];
                        state        <= (num_samples == 32'd0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (read_req) begin
                        next_word  <= next_word + WORD_W'(1);
                        words_left <= words_left - (WORD_W + 1)'(1);
                        if (words_left == (WORD_W + 1)'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: ;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            if (handshake) samples_left <= samples_left - 32'd1;
            if (handshake && final_sample) state <= ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({read_req, get_return_data})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Head register: reloads in the same cycle the old word retires, so
    // consecutive words stream without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_valid    <= 1'b0;
            head_data     <= '0;
            lane          <= '0;
            first_pending <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) first_pending <= 1'b1;
            if (fifo_rd) begin
                head_valid    <= 1'b1;
                head_data     <= fifo_rd_data;
                lane          <= first_pending ? first_lane : '0;
                first_pending <= 1'b0;
            end else if (word_done) begin
                head_valid <= 1'b0;
            end else if (handshake) begin
                lane <= lane + LANE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dram_unpacker.sv
// Self-checking bench: a DDR model with fixed return latency feeds the
// unpacker; expected read addresses and samples are queued at each start.
module tb_dram_unpacker;

    localparam int LAT = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [31:0]  start_sample;
    logic [31:0]  num_samples;
    logic         busy;
    logic         done;
    logic         read_req;
    logic [26:0]  rd_adx;
    logic         read_allowed;
    logic         has_return_data;
    logic [127:0] return_data;
    logic         get_return_data;
    logic         sample_valid;
    logic         sample_ready;
    logic [31:0]  sample_data;
    logic         sample_last;

    dram_unpacker #(.FIFO_DEPTH(4), .ADX_W(27)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .start_sample    (start_sample),
        .num_samples     (num_samples),
        .busy            (busy),
        .done            (done),
        .read_req        (read_req),
        .rd_adx          (rd_adx),
        .read_allowed    (read_allowed),
        .has_return_data (has_return_data),
        .return_data     (return_data),
        .get_return_data (get_return_data),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .sample_data     (sample_data),
        .sample_last     (sample_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] adx;
        int          due;
    } pend_t;

    logic [26:0] exp_adx [$];
    logic [32:0] exp_smp [$];
    pend_t       pend [$];
    logic [26:0] ret [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    int done_cyc = -1;
    int last_hs_cyc = -1;
    int first_rd_cyc = -1;
    int first_pop_cyc = -1;
    int first_sv_cyc = -1;
    int st_cyc = 0;
    bit hold = 1'b0;
    bit rdy_rand = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] build_word(input logic [26:0] adx);
        logic [127:0] w;
        logic [23:0]  wi;
        logic [1:0]   ll;
        wi = adx[26:3];
        w  = '0;
        for (int l = 0; l < 4; l++) begin
            ll = 2'(l);
            w[l*32 +: 32] = {6'h2A, wi, ll};
        end
        return w;
    endfunction

    // DDR model and output monitor: observe at negedge, drive after posedge.
    initial begin
        pend_t       tmp;
        logic [32:0] e;
        logic        stall_prev;
        logic [32:0] stall_val;
        has_return_data = 1'b0;
        return_data     = '0;
        read_allowed    = 1'b1;
        sample_ready    = 1'b1;
        stall_prev      = 1'b0;
        stall_val       = '0;
        forever begin
            @(negedge clk);
            if (read_req === 1'b1) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (exp_adx.size() == 0) check("adx_extra", 1, 0);
                else check("rd_adx", rd_adx, exp_adx.pop_front());
                tmp.adx = rd_adx;
                tmp.due = cyc + LAT;
                pend.push_back(tmp);
            end
            if (get_return_data === 1'b1) begin
                pop_cnt++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                check("pop_has", has_return_data, 1);
                if (ret.size() > 0) void'(ret.pop_front());
            end
            if (sample_valid === 1'b1 && first_sv_cyc < 0) first_sv_cyc = cyc;
            if (sample_valid === 1'b1 && sample_ready) begin
                if (exp_smp.size() == 0) check("smp_extra", 1, 0);
                else begin
                    e = exp_smp.pop_front();
                    check("smp_data", sample_data, e[31:0]);
                    check("smp_last", sample_last, e[32]);
                end
                if (sample_last === 1'b1) last_hs_cyc = cyc;
            end
            if (stall_prev && !reset) check("stall_hold", {sample_valid, sample_last, sample_data}, {1'b1, stall_val});
            stall_prev = !reset && (sample_valid === 1'b1) && !sample_ready;
            stall_val  = {sample_last, sample_data};
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", busy, 0);
            end
            if (busy === 1'b1) busy_cyc++;

            @(posedge clk);
            #1;
            cyc++;
            while (pend.size() > 0 && pend[0].due <= cyc) begin
                tmp = pend.pop_front();
                ret.push_back(tmp.adx);
            end
            has_return_data = (ret.size() > 0) && !hold;
            return_data     = (ret.size() > 0) ? build_word(ret[0]) : '0;
            sample_ready    = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] n);
        logic [25:0] idx;
        logic [23:0] w;
        logic [23:0] pw;
        pw = '0;
        for (int k = 0; k < int'(n); k++) begin
            idx = s[25:0] + 26'(k);
            w   = idx[25:2];
            if (k == 0 || w != pw) exp_adx.push_back({w, 3'b000});
            pw = w;
            exp_smp.push_back({(k == int'(n) - 1), 6'h2A, idx});
        end
        first_rd_cyc  = -1;
        first_pop_cyc = -1;
        first_sv_cyc  = -1;
        start_sample  = s;
        num_samples   = n;
        start         = 1'b1;
        st_cyc        = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        if (done_cnt == d0) check({tag, "_timeout"}, 0, 1);
        else begin
            tick(3);
            check({tag, "_done_once"}, done_cnt - d0, 1);
        end
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_adx_left"}, exp_adx.size(), 0);
        check({tag, "_smp_left"}, exp_smp.size(), 0);
    endtask

    initial begin
        int r0;
        int b0;
        int p0;
        reset        = 1'b1;
        start        = 1'b0;
        start_sample = '0;
        num_samples  = '0;
        tick(3);
        check("rst_ctl", {busy, done, read_req, get_return_data, sample_valid, sample_last}, 0);
        check("rst_dat", {rd_adx, sample_data}, 0);
        reset = 1'b0;
        tick(2);

        // aligned 8-sample run
        r0 = rd_cnt;
        do_start(32'd0, 32'd8);
        check("t1_busy", busy, 1);
        wait_done("t1", 200);
        check("t1_first_rd", first_rd_cyc, st_cyc + 1);
        check("t1_rd_cnt", rd_cnt - r0, 2);
        check("t1_sv_lat", (first_sv_cyc - first_pop_cyc) >= 2, 1);
        check("t1_done_cyc", done_cyc, last_hs_cyc + 1);
        check_drained("t1");

        // unaligned start, partial last word
        r0 = rd_cnt;
        do_start(32'd6, 32'd3);
        wait_done("t2", 200);
        check("t2_rd_cnt", rd_cnt - r0, 2);
        check("t2_done_cyc", done_cyc, last_hs_cyc + 1);
        check_drained("t2");

        // zero-length request
        r0 = rd_cnt;
        b0 = busy_cyc;
        do_start(32'd100, 32'd0);
        wait_done("t3", 20);
        check("t3_done_cyc", done_cyc, st_cyc + 1);
        check("t3_rd_cnt", rd_cnt - r0, 0);
        check("t3_busy_cyc", busy_cyc - b0, 0);

        // credit limit with returns withheld
        r0 = rd_cnt;
        hold = 1'b1;
        do_start(32'd0, 32'd40);
        tick(50);
        check("t4_rd_stall", rd_cnt - r0, 4);
        check("t4_outstanding", pend.size() + ret.size(), 4);
        check("t4_req_low", read_req, 0);
        hold = 1'b0;
        wait_done("t4", 400);
        check("t4_rd_cnt", rd_cnt - r0, 10);
        check_drained("t4");

        // random backpressure with an ignored start mid-run
        r0 = rd_cnt;
        rdy_rand = 1'b1;
        do_start(32'd13, 32'd20);
        tick(8);
        start_sample = 32'd100;
        num_samples  = 32'd5;
        start        = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("t5", 400);
        rdy_rand = 1'b0;
        check("t5_rd_cnt", rd_cnt - r0, 6);
        check_drained("t5");

        // wrap of the sample ring and address space
        r0 = rd_cnt;
        do_start(32'h03FF_FFFE, 32'd4);
        wait_done("t6", 200);
        check("t6_rd_cnt", rd_cnt - r0, 2);
        check_drained("t6");

        // reset in the middle of a run
        rdy_rand = 1'b1;
        do_start(32'd0, 32'd40);
        tick(12);
        reset = 1'b1;
        tick(1);
        check("t7_rst_ctl", {busy, done, read_req, get_return_data, sample_valid, sample_last}, 0);
        check("t7_rst_dat", {rd_adx, sample_data}, 0);
        tick(1);
        reset = 1'b0;
        exp_adx.delete();
        exp_smp.delete();
        p0 = pop_cnt;
        tick(12);
        check("t7_no_pop", pop_cnt - p0, 0);
        check("t7_get_low", get_return_data, 0);
        check("t7_idle", busy, 0);
        rdy_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
